ext_mem_responder: RTL and testbench

Synthesizable dual-channel off-chip byte memory that answers the HLS core's master memory port (`Mout_*` → `M_Rdata_ram` / `M_DataRdy`).

- Sits directly downstream of the generated `main` accelerator.
- Replaces the behavioural memory model on FPGA prototypes.
- Serves per-channel reads and writes with fixed, parameterized latencies.
- Provides a preload port so the host can load input vectors before `start_port`.

---
 rtl/ext_mem_pkg.sv | 16 +
 rtl/ext_mem_channel_ctrl.sv | 104 ++++++++++
 rtl/ext_mem_responder.sv | 84 ++++++++
 tb/tb_ext_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and helpers for the dual-channel external byte memory responder.
package ext_mem_pkg;
  localparam int DEF_READ_LATENCY  = 2;
  localparam int DEF_WRITE_LATENCY = 1;
  localparam int NUM_CH            = 2;
  localparam int CNT_W             = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_WR_WAIT} ch_state_e;

  // Sizes of 8 bits or more cover the whole byte.
  function automatic logic [7:0] size_to_mask(input logic [3:0] size);
    logic [8:0] m;
    m = (9'd1 << size) - 9'd1;
    return (size >= 4'd8) ? 8'hFF : m[7:0];
  endfunction
endpackage

// File: rtl/ext_mem_channel_ctrl.sv
// One memory channel: range check, latency FSM and response gating.
module ext_mem_channel_ctrl
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W        = 7,
  parameter int BASE_ADDR     = 0,
  parameter int DEPTH         = 32,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY,
  localparam int OFF_W        = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              oe,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic [3:0]        size,
  input  logic [7:0]        rd_byte,
  output logic [OFF_W-1:0]  rd_off,
  output logic              wr_en,
  output logic [OFF_W-1:0]  wr_off,
  output logic [7:0]        wr_data,
  output logic [7:0]        wr_mask,
  output logic              data_rdy,
  output logic [7:0]        rdata
);
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rd_byte_q, rd_byte_d;
  int               addr_i;
  logic             in_range, rd_hold, wr_hold, rdy_rd, rdy_wr;
  logic [OFF_W-1:0] off;

  assign addr_i   = int'(32'(addr));
  assign in_range = (addr_i >= BASE_ADDR) && (addr_i < BASE_ADDR + DEPTH);
  assign off      = OFF_W'(addr_i - BASE_ADDR);
  // oe together with we is served as a read.
  assign rd_hold  = oe && in_range;
  assign wr_hold  = we && !oe && in_range;
  assign rdy_rd   = (state_q == ST_RD_WAIT) && rd_hold &&
                    (cnt_q == CNT_W'(READ_LATENCY - 1));
  assign rdy_wr   = wr_hold &&
                    (((state_q == ST_IDLE) && (WRITE_LATENCY == 1)) ||
                     ((state_q == ST_WR_WAIT) && (cnt_q == CNT_W'(WRITE_LATENCY - 1))));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    // Byte is re-captured every edge a read is held; the strobe cycle shows the last capture.
    rd_byte_d = rd_hold ? rd_byte : rd_byte_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_hold) begin
          state_d = ST_RD_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (wr_hold && (WRITE_LATENCY > 1)) begin
          state_d = ST_WR_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RD_WAIT: begin
        if (!rd_hold || rdy_rd) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_WAIT: begin
        if (!wr_hold || rdy_wr) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_byte_q <= rd_byte_d;
    end
  end

  assign rd_off   = off;
  assign wr_off   = off;
  assign wr_data  = wdata;
  assign wr_mask  = size_to_mask(size);
  assign wr_en    = rdy_wr && !reset;
  assign data_rdy = (rdy_rd || rdy_wr) && !reset;
  assign rdata    = (rdy_rd && !reset) ? rd_byte_q : 8'h00;
endmodule

// File: rtl/ext_mem_responder.sv
// Dual-channel off-chip byte memory answering the HLS master port, with host preload.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W        = 7,
  parameter int BASE_ADDR     = 0,
  parameter int DEPTH         = 32,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY,
  localparam int OFF_W        = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        Mout_oe_ram,
  input  logic [NUM_CH-1:0]        Mout_we_ram,
  input  logic [NUM_CH*ADDR_W-1:0] Mout_addr_ram,
  input  logic [NUM_CH*8-1:0]      Mout_Wdata_ram,
  input  logic [NUM_CH*4-1:0]      Mout_data_ram_size,
  output logic [NUM_CH*8-1:0]      M_Rdata_ram,
  output logic [NUM_CH-1:0]        M_DataRdy,
  input  logic                     ld_we,
  input  logic [OFF_W-1:0]         ld_addr,
  input  logic [7:0]               ld_data,
  output logic                     err_both
);
  logic [7:0]                   mem_q [DEPTH];
  logic [NUM_CH-1:0][OFF_W-1:0] rd_off, wr_off;
  logic [NUM_CH-1:0][7:0]       wr_data, wr_mask, rd_byte, rdata;
  logic [NUM_CH-1:0]            wr_en, data_rdy;
  logic                         err_both_q, err_both_d;
  logic                         ld_in;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ext_mem_channel_ctrl #(
      .ADDR_W       (ADDR_W),
      .BASE_ADDR    (BASE_ADDR),
      .DEPTH        (DEPTH),
      .READ_LATENCY (READ_LATENCY),
      .WRITE_LATENCY(WRITE_LATENCY)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .oe      (Mout_oe_ram[g]),
      .we      (Mout_we_ram[g]),
      .addr    (Mout_addr_ram[ADDR_W*g +: ADDR_W]),
      .wdata   (Mout_Wdata_ram[8*g +: 8]),
      .size    (Mout_data_ram_size[4*g +: 4]),
      .rd_byte (rd_byte[g]),
      .rd_off  (rd_off[g]),
      .wr_en   (wr_en[g]),
      .wr_off  (wr_off[g]),
      .wr_data (wr_data[g]),
      .wr_mask (wr_mask[g]),
      .data_rdy(data_rdy[g]),
      .rdata   (rdata[g])
    );
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      rd_byte[c] = (int'(32'(rd_off[c])) < DEPTH) ? mem_q[rd_off[c]] : 8'h00;
  end

  assign ld_in = int'(32'(ld_addr)) < DEPTH;

  // Later assignments win: preload < ch0 < ch1. Merges read the pre-edge byte.
  always_ff @(posedge clock) begin
    if (ld_we && ld_in) mem_q[ld_addr] <= ld_data;
    for (int c = 0; c < NUM_CH; c++)
      if (wr_en[c])
        mem_q[wr_off[c]] <= (wr_data[c] & wr_mask[c]) | (mem_q[wr_off[c]] & ~wr_mask[c]);
  end

  assign err_both_d = err_both_q || |(Mout_oe_ram & Mout_we_ram);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_both_q <= 1'b0;
    else       err_both_q <= err_both_d;
  end

  assign M_Rdata_ram = rdata;
  assign M_DataRdy   = data_rdy;
  assign err_both    = err_both_q;
endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: two instances (fast and slow latencies) against a request-age model.
module tb_ext_mem_responder;
  localparam int AW = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    oe = '0, we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [15:0]   wdata = '0;
  logic [7:0]    size = '0;
  logic          ld_we = 1'b0;
  logic [4:0]    ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic [15:0]   rdata_a, rdata_b;
  logic [1:0]    rdy_a, rdy_b;
  logic          err_a, err_b;
  int            n_run = 0, n_fail = 0;

  always #5 clock = ~clock;

  ext_mem_responder #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(32), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size), .M_Rdata_ram(rdata_a), .M_DataRdy(rdy_a),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .err_both(err_a));

  ext_mem_responder #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(32), .READ_LATENCY(3), .WRITE_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size), .M_Rdata_ram(rdata_b), .M_DataRdy(rdy_b),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .err_both(err_b));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- model ----------------
  logic [7:0] m_mem  [2][32];
  int         m_busy [2][2];   // 0 none, 1 read, 2 write
  int         m_age  [2][2];
  logic [7:0] m_prev [2][2];   // byte seen at the offset last cycle
  bit         m_err  [2];

  function automatic int m_lat(int d, bit rd);
    if (rd) return (d == 0) ? 2 : 3;
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] m_mask(int s);
    if (s >= 8) return 8'hFF;
    return 8'((1 << s) - 1);
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) m_mem[d][i] = 8'h00;
      for (int c = 0; c < 2; c++) begin m_busy[d][c] = 0; m_age[d][c] = 0; m_prev[d][c] = 8'h00; end
      m_err[d] = 1'b0;
    end
  end

  always @(negedge clock) begin : mdl
    logic [1:0]  e_rdy, a_rdy;
    logic [15:0] e_rd, a_rd;
    logic        a_err;
    logic [31:0] ad;
    logic [7:0]  nv [2];
    int          op [2], cur [2], off [2];
    for (int d = 0; d < 2; d++) begin
      a_rdy = (d == 0) ? rdy_a : rdy_b;
      a_rd  = (d == 0) ? rdata_a : rdata_b;
      a_err = (d == 0) ? err_a : err_b;
      e_rdy = '0;
      e_rd  = '0;
      for (int c = 0; c < 2; c++) begin op[c] = 0; cur[c] = 0; off[c] = 0; end
      if (reset) begin
        for (int c = 0; c < 2; c++) begin m_busy[d][c] = 0; m_age[d][c] = 0; end
        m_err[d] = 1'b0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          ad     = 32'(addr[AW*c +: AW]);
          off[c] = int'(ad);
          if (ad >= 32)    op[c] = 0;
          else if (oe[c])  op[c] = 1;
          else if (we[c])  op[c] = 2;
          else             op[c] = 0;
          cur[c] = (op[c] != 0 && op[c] == m_busy[d][c]) ? m_age[d][c] + 1 : 0;
          if (op[c] != 0 && cur[c] == m_lat(d, op[c] == 1) - 1) begin
            e_rdy[c] = 1'b1;
            if (op[c] == 1) e_rd[8*c +: 8] = m_prev[d][c];
          end
        end
      end
      chk($sformatf("dut%0d DataRdy", d), 32'(a_rdy), 32'(e_rdy));
      chk($sformatf("dut%0d Rdata", d), 32'(a_rd), 32'(e_rd));
      chk($sformatf("dut%0d err_both", d), 32'(a_err), 32'(m_err[d]));
      if (!reset) begin
        for (int c = 0; c < 2; c++) begin
          m_busy[d][c] = e_rdy[c] ? 0 : op[c];
          m_age[d][c]  = cur[c];
          nv[c] = 8'h00;
          if (op[c] != 0) begin
            m_prev[d][c] = m_mem[d][off[c]];
            nv[c] = (wdata[8*c +: 8] & m_mask(int'(size[4*c +: 4]))) |
                    (m_mem[d][off[c]] & ~m_mask(int'(size[4*c +: 4])));
          end
        end
        if ((oe & we) != 2'b00) m_err[d] = 1'b1;
        if (ld_we) m_mem[d][ld_addr] = ld_data;
        for (int c = 0; c < 2; c++)
          if (e_rdy[c] && op[c] == 2) m_mem[d][off[c]] = nv[c];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    oe = '0; we = '0; ld_we = 1'b0;
  endtask

  task automatic set_ch(int c, bit o, bit w, int a, logic [7:0] dat, logic [3:0] sz);
    oe[c] = o;
    we[c] = w;
    addr[AW*c +: AW]  = AW'(a);
    wdata[8*c +: 8]   = dat;
    size[4*c +: 4]    = sz;
  endtask

  initial begin
    repeat (3) begin
      @(negedge clock);
      chk("reset DataRdy", 32'({rdy_a, rdy_b}), 32'h0);
      chk("reset err", 32'({err_a, err_b}), 32'h0);
    end
    tick();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      ld_we = 1'b1; ld_addr = 5'(i); ld_data = 8'(i * 7 + 3);
      tick();
    end
    idle();

    // preload and read
    ld_we = 1'b1; ld_addr = 5'd5; ld_data = 8'hA7;
    tick();
    idle();
    set_ch(0, 1, 0, 5, 8'h00, 4'd8);
    @(negedge clock);
    chk("rd c0 rdy", 32'(rdy_a[0]), 32'h0);
    chk("rd c0 data", 32'(rdata_a), 32'h0);
    tick();
    @(negedge clock);
    chk("rd c1 rdy", 32'(rdy_a[0]), 32'h1);
    chk("rd c1 data", 32'(rdata_a[7:0]), 32'hA7);
    tick();
    @(negedge clock);
    chk("rd c2 rdy", 32'(rdy_a[0]), 32'h0);
    chk("rd lat3 data", 32'(rdata_b[7:0]), 32'hA7);
    tick();
    idle();
    tick();

    // masked write
    ld_we = 1'b1; ld_addr = 5'd3; ld_data = 8'hFF;
    tick();
    idle();
    set_ch(1, 0, 1, 3, 8'h00, 4'd4);
    @(negedge clock);
    chk("mwr c0 rdy", 32'(rdy_a[1]), 32'h1);
    tick();
    tick();
    @(negedge clock);
    chk("mwr lat3 rdy", 32'(rdy_b[1]), 32'h1);
    tick();
    idle();
    tick();
    set_ch(1, 1, 0, 3, 8'h00, 4'd0);
    tick();
    @(negedge clock);
    chk("mwr readback", 32'(rdata_a[15:8]), 32'hF0);
    tick();
    @(negedge clock);
    chk("mwr readback lat3", 32'(rdata_b[15:8]), 32'hF0);
    tick();
    idle();
    tick();

    // out of range
    set_ch(0, 1, 0, 32, 8'h00, 4'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("oor rdy", 32'(rdy_a), 32'h0);
      chk("oor data", 32'(rdata_a), 32'h0);
      tick();
    end
    idle();
    tick();

    // write collision, then read racing a write
    set_ch(0, 0, 1, 7, 8'h11, 4'd8);
    set_ch(1, 0, 1, 7, 8'h22, 4'd8);
    tick();
    idle();
    tick();
    set_ch(0, 1, 0, 7, 8'h00, 4'd8);
    set_ch(1, 0, 1, 7, 8'h33, 4'd8);
    tick();
    we[1] = 1'b0;
    @(negedge clock);
    chk("collide old value", 32'(rdata_a[7:0]), 32'h22);
    tick();
    tick();
    idle();
    tick();
    set_ch(0, 1, 0, 7, 8'h00, 4'd8);
    tick();
    @(negedge clock);
    chk("collide new value", 32'(rdata_a[7:0]), 32'h33);
    tick();
    idle();
    tick();

    // preload vs channel write on one offset
    ld_we = 1'b1; ld_addr = 5'd9; ld_data = 8'h55;
    set_ch(0, 0, 1, 9, 8'h66, 4'd8);
    tick();
    idle();
    tick();
    set_ch(0, 1, 0, 9, 8'h00, 4'd8);
    tick();
    @(negedge clock);
    chk("ld vs ch write", 32'(rdata_a[7:0]), 32'h66);
    tick();
    @(negedge clock);
    chk("ld only lat3", 32'(rdata_b[7:0]), 32'h55);
    tick();
    idle();
    tick();

    // oe and we together
    set_ch(1, 1, 1, 10, 8'hEE, 4'd8);
    @(negedge clock);
    chk("err before", 32'(err_a), 32'h0);
    tick();
    @(negedge clock);
    chk("err after", 32'(err_a), 32'h1);
    chk("err read data", 32'(rdata_a[15:8]), 32'h49);
    tick();
    idle();
    repeat (4) tick();
    @(negedge clock);
    chk("err sticky", 32'({err_a, err_b}), 32'h3);
    tick();

    // reset in the strobe cycle of a slow write
    set_ch(0, 0, 1, 12, 8'hAB, 4'd8);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst abort rdy", 32'(rdy_b), 32'h0);
    chk("rst abort data", 32'(rdata_b), 32'h0);
    chk("rst err clear", 32'(err_b), 32'h0);
    tick();
    idle();
    tick();
    reset = 1'b0;
    tick();
    set_ch(0, 1, 0, 12, 8'h00, 4'd8);
    tick();
    @(negedge clock);
    chk("rst fast commit", 32'(rdata_a[7:0]), 32'hAB);
    tick();
    @(negedge clock);
    chk("rst slow rdy", 32'(rdy_b[0]), 32'h1);
    chk("rst slow unchanged", 32'(rdata_b[7:0]), 32'h57);
    tick();
    idle();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
